// File: rtl/uart_result_sender.sv
// uart_result_sender: requests bytes from an upstream serializer and
// sends each one as an 8N1 UART character, BYTES_PER_FRAME per result.
module uart_result_sender #(
  parameter int unsigned CLKS_PER_BIT    = 434,
  parameter int unsigned BYTES_PER_FRAME = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_byte,
  input  logic       in_byte_valid,
  output logic       data_request,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_BYTE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    DONE
  } state_t;

  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  FRAME_BYTES = 8'(BYTES_PER_FRAME);
  localparam logic [3:0]  WAIT_LAST   = 4'd14;

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  byte_cnt, byte_n;
  logic [3:0]  wait_cnt, wait_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n;
  logic        req_n;
  logic        busy_n;
  logic        done_n;
  logic        timeout_n;
  logic        baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Next-state, counter updates and next registered outputs.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    byte_n    = byte_cnt;
    wait_n    = wait_cnt;
    shift_n   = shift;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = REQ;
          byte_n  = '0;
        end
      end
      REQ: begin
        state_n = WAIT_BYTE;
        wait_n  = '0;
      end
      WAIT_BYTE: begin
        if (in_byte_valid) begin
          shift_n = in_byte;
          baud_n  = '0;
          state_n = START_BIT;
        end else begin
          wait_n = wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) begin
            timeout_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      START_BIT: begin
        if (baud_wrap) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA_BITS;
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      DATA_BITS: begin
        if (baud_wrap) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP_BIT;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      STOP_BIT: begin
        if (baud_wrap) begin
          baud_n = '0;
          byte_n = byte_cnt + 8'd1;
          if (byte_n < FRAME_BYTES) begin
            state_n = REQ;
          end else begin
            state_n = DONE;
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    unique case (state_n)
      START_BIT: tx_n = 1'b0;
      DATA_BITS: tx_n = shift_n[bit_n];
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    req_n  = (state_n == REQ);
    done_n = (state_n == DONE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
      shift        <= '0;
      tx           <= 1'b1;
      data_request <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_n;
      bit_idx      <= bit_n;
      byte_cnt     <= byte_n;
      wait_cnt     <= wait_n;
      shift        <= shift_n;
      tx           <= tx_n;
      data_request <= req_n;
      busy         <= busy_n;
      frame_done   <= done_n;
      timeout_err  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_uart_result_sender.sv
// tb_uart_result_sender: random frames checked against a line-level
// UART reference (expected 40-sample waveform per byte) and pulse counts.
module tb_uart_result_sender;

  localparam int CPB = 4;
  localparam int BPF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_byte;
  logic       in_byte_valid;
  logic       data_request;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  logic       rsp_valid = 1'b0;
  logic       stray_valid = 1'b0;
  logic [7:0] rsp_byte = 8'h00;
  logic [7:0] stray_byte = 8'h00;

  assign in_byte_valid = rsp_valid | stray_valid;
  assign in_byte = stray_valid ? stray_byte : rsp_byte;

  uart_result_sender #(
    .CLKS_PER_BIT(CPB),
    .BYTES_PER_FRAME(BPF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_byte(in_byte),
    .in_byte_valid(in_byte_valid),
    .data_request(data_request),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int req_pulses = 0, fd_pulses = 0, to_pulses = 0;
  int last_req_cyc = 0, fd_cyc = 0, to_cyc = 0;

  // Pulse counters and timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (data_request === 1'b1) begin
      req_pulses++;
      last_req_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      fd_pulses++;
      fd_cyc = cyc;
    end
    if (timeout_err === 1'b1) begin
      to_pulses++;
      to_cyc = cyc;
    end
  end

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int rsp_budget = 1000;

  // Upstream model: answer each request one cycle later.
  always begin
    @(negedge clk);
    if (data_request === 1'b1 && rsp_budget > 0) begin
      rsp_budget--;
      @(posedge clk);
      #1;
      if (src_q.size() > 0) rsp_byte = src_q.pop_front();
      else rsp_byte = 8'($urandom);
      exp_q.push_back(rsp_byte);
      rsp_valid = 1'b1;
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
    end
  end

  int bytes_seen = 0;
  int last_stop_cyc = 0;
  logic [39:0] last_wave = '0;
  logic tx_prev = 1'b1;

  // Line reference: collect 10 bits x CPB samples after a falling edge.
  always begin
    logic [39:0] wave, expw;
    logic [9:0]  fr;
    logic [7:0]  b;
    bit          aborted;
    @(negedge clk);
    if (rst_n === 1'b1 && tx_prev === 1'b1 && tx === 1'b0) begin
      aborted = 1'b0;
      wave = '0;
      for (int i = 0; i < 10 * CPB && !aborted; i++) begin
        if (i > 0) @(negedge clk);
        if (rst_n !== 1'b1) aborted = 1'b1;
        wave[i] = tx;
      end
      if (aborted) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        chk("unexpected_byte", 64'(wave), 64'h0);
      end else begin
        b = exp_q.pop_front();
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) expw[k] = fr[k / CPB];
        chk("byte_wave", 64'(wave), 64'(expw));
        last_wave = wave;
        bytes_seen++;
        last_stop_cyc = cyc;
      end
    end
    tx_prev = tx;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit with_valid);
    start = 1'b1;
    stray_valid = with_valid;
    stray_byte = 8'hA5;
    tick(1);
    start = 1'b0;
    stray_valid = 1'b0;
  endtask

  task automatic pulse_stray();
    stray_byte = 8'hFF;
    stray_valid = 1'b1;
    tick(1);
    stray_valid = 1'b0;
  endtask

  // mode 0 plain, 1 mid-frame start/stray valid, 2 start+valid together.
  task automatic run_frame(input int mode);
    int r0, f0, b0, t0, n;
    r0 = req_pulses;
    f0 = fd_pulses;
    b0 = bytes_seen;
    t0 = to_pulses;
    pulse_start(mode == 2);
    if (mode == 1) begin
      tick(12);
      pulse_stray();
      pulse_start(1'b0);
      tick(35);
      pulse_stray();
      pulse_start(1'b0);
    end
    n = 0;
    while (fd_pulses == f0 && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) chk("frame_wait_expired", 64'd0, 64'd1);
    tick(3);
    chk("req_pulses", 64'(req_pulses - r0), 64'(BPF));
    chk("frame_done_cnt", 64'(fd_pulses - f0), 64'd1);
    chk("bytes_seen", 64'(bytes_seen - b0), 64'(BPF));
    chk("fd_after_stop", 64'(fd_cyc - last_stop_cyc), 64'd1);
    chk("timeout_none", 64'(to_pulses - t0), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("tx_idle", 64'(tx), 64'd1);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_random();
    src_q.delete();
    for (int i = 0; i < BPF; i++) src_q.push_back(8'($urandom));
  endtask

  initial begin
    int r0, f0, b0, t0, n;
    rst_n = 1'b0;
    tick(2);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'(data_request), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_to", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    tick(2);

    src_q = '{8'h35, 8'h35, 8'h35, 8'h35};
    run_frame(0);
    chk("wave_0x35", 64'(last_wave), 64'h00_00F0_0FF0_F0F0);

    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(0);

    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_frame(0);
    end

    fill_random();
    run_frame(2);

    fill_random();
    run_frame(1);

    fill_random();
    rsp_budget = 1;
    r0 = req_pulses;
    f0 = fd_pulses;
    b0 = bytes_seen;
    t0 = to_pulses;
    pulse_start(1'b0);
    n = 0;
    while (to_pulses == t0 && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) chk("timeout_wait_expired", 64'd0, 64'd1);
    chk("timeout_delay", 64'(to_cyc - last_req_cyc), 64'd16);
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_tx", 64'(tx), 64'd1);
    tick(3);
    chk("timeout_cnt", 64'(to_pulses - t0), 64'd1);
    chk("timeout_reqs", 64'(req_pulses - r0), 64'd2);
    chk("timeout_no_fd", 64'(fd_pulses - f0), 64'd0);
    chk("timeout_bytes", 64'(bytes_seen - b0), 64'd1);
    rsp_budget = 1000;
    src_q.delete();
    exp_q.delete();

    fill_random();
    f0 = fd_pulses;
    b0 = bytes_seen;
    t0 = to_pulses;
    pulse_start(1'b0);
    tick(97);
    rst_n = 1'b0;
    tick(1);
    chk("abort_tx", 64'(tx), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick(50);
    chk("abort_no_fd", 64'(fd_pulses - f0), 64'd0);
    chk("abort_no_to", 64'(to_pulses - t0), 64'd0);
    chk("abort_bytes", 64'(bytes_seen - b0), 64'd2);
    src_q.delete();
    exp_q.delete();

    fill_random();
    run_frame(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
